bayer_column_feeder: RTL

Raster-to-column line buffer that produces the three vertically aligned pixel taps consumed each cycle by the 3x3 green window buffer in the demosaic pipeline. It accepts one Bayer pixel per valid cycle in raster order and stores the two previous image rows internally. For every accepted pixel it emits the column (row y-2, row y-1, row y) at that x position. It also tracks frame position and flags when the taps are meaningful.

---
 rtl/bayer_column_feeder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/bayer_column_feeder.sv
// bayer_column_feeder
// Raster-to-column line buffer: accepts one Bayer pixel per valid cycle and
// emits the vertically aligned column (y-2, y-1, y) at the same x position,
// together with frame position, a tap-valid flag and an end-of-frame pulse.
module bayer_column_feeder #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DATA_W     = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             pix_in,
  input  logic                          pix_valid,
  input  logic                          sof,
  output logic [DATA_W-1:0]             col_top,
  output logic [DATA_W-1:0]             col_mid,
  output logic [DATA_W-1:0]             col_bot,
  output logic                          tap_valid,
  output logic [$clog2(IMG_WIDTH)-1:0]  tap_x,
  output logic [$clog2(IMG_HEIGHT)-1:0] tap_y,
  output logic                          eof
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t            state_r;
  logic [XW-1:0]     x_r;
  logic [YW-1:0]     y_r;

  // Line arrays are deliberately not reset: FILL keeps tap_valid low until
  // both rows have been rewritten by the current frame.
  logic [DATA_W-1:0] lb_mid_r [IMG_WIDTH];
  logic [DATA_W-1:0] lb_top_r [IMG_WIDTH];

  logic              restart_s;
  logic              accept_s;
  logic [XW-1:0]     cur_x_s;
  logic [YW-1:0]     cur_y_s;
  logic [XW-1:0]     nxt_x_s;
  logic [YW-1:0]     nxt_y_s;
  logic              row_end_s;
  logic              frame_end_s;

  // Decode which pixel is accepted, its coordinates and the next raster position.
  always_comb begin
    restart_s   = pix_valid & sof;
    accept_s    = 1'b0;
    cur_x_s     = x_r;
    cur_y_s     = y_r;
    nxt_x_s     = x_r;
    nxt_y_s     = y_r;
    row_end_s   = 1'b0;
    frame_end_s = 1'b0;

    // In IDLE only a start-of-frame pixel is taken; otherwise every valid pixel is.
    if (state_r == IDLE) begin
      accept_s = restart_s;
    end else begin
      accept_s = pix_valid;
    end

    // A sof pixel is always (0,0), whatever the counters currently say.
    if (restart_s) begin
      cur_x_s = {XW{1'b0}};
      cur_y_s = {YW{1'b0}};
    end else begin
      cur_x_s = x_r;
      cur_y_s = y_r;
    end

    row_end_s   = (cur_x_s == XW'(IMG_WIDTH - 1));
    frame_end_s = row_end_s && (cur_y_s == YW'(IMG_HEIGHT - 1));

    if (row_end_s) begin
      nxt_x_s = {XW{1'b0}};
      nxt_y_s = cur_y_s + YW'(1);
    end else begin
      nxt_x_s = cur_x_s + XW'(1);
      nxt_y_s = cur_y_s;
    end
  end

  // Shift the column through the line arrays (read-before-write at cur_x).
  always_ff @(posedge clk) begin
    if (!rst && accept_s) begin
      lb_top_r[cur_x_s] <= lb_mid_r[cur_x_s];
      lb_mid_r[cur_x_s] <= pix_in;
    end
  end

  // Frame-position FSM with registered column taps and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      x_r       <= {XW{1'b0}};
      y_r       <= {YW{1'b0}};
      col_top   <= {DATA_W{1'b0}};
      col_mid   <= {DATA_W{1'b0}};
      col_bot   <= {DATA_W{1'b0}};
      tap_valid <= 1'b0;
      tap_x     <= {XW{1'b0}};
      tap_y     <= {YW{1'b0}};
      eof       <= 1'b0;
    end else begin
      tap_valid <= 1'b0;
      eof       <= 1'b0;
      if (accept_s) begin
        col_top <= lb_top_r[cur_x_s];
        col_mid <= lb_mid_r[cur_x_s];
        col_bot <= pix_in;
        tap_x   <= cur_x_s;
        tap_y   <= cur_y_s;
        if (restart_s) begin
          // Start (or abort and restart) a frame; the aborted frame gets no eof.
          state_r <= FILL;
          x_r     <= nxt_x_s;
          y_r     <= nxt_y_s;
        end else begin
          case (state_r)
            FILL: begin
              x_r <= nxt_x_s;
              y_r <= nxt_y_s;
              if (row_end_s && (cur_y_s == YW'(1))) begin
                state_r <= STREAM;
              end else begin
                state_r <= FILL;
              end
            end
            STREAM: begin
              tap_valid <= 1'b1;
              if (frame_end_s) begin
                eof     <= 1'b1;
                state_r <= IDLE;
                x_r     <= {XW{1'b0}};
                y_r     <= {YW{1'b0}};
              end else begin
                x_r <= nxt_x_s;
                y_r <= nxt_y_s;
              end
            end
            default: begin
              state_r <= IDLE;
              x_r     <= {XW{1'b0}};
              y_r     <= {YW{1'b0}};
            end
          endcase
        end
      end
    end
  end

endmodule
